// File: rtl/fp_sqrt_unit.sv
// Iterative binary32 square root: one root bit per clock, IEEE rounding and flags.
// Optional FP_SQRT_EARLY_OUT_EN lets special-class operands finish one edge after start.
module fp_sqrt_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] a_i,
    input  logic        start_i,
    input  logic [2:0]  rnd_i,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    function automatic logic [4:0] lzc24(input logic [23:0] x);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (x[i]) n = 5'(23 - i);
            else      n = n;
        end
        return n;
    endfunction

    function automatic logic round_inc(input logic [2:0] rm, input logic g, input logic s, input logic l);
        logic inc;
        case (rm)
            3'd1, 3'd2: inc = 1'b0;
            3'd3:       inc = g | s;
            3'd4:       inc = g;
            default:    inc = g & (s | l);
        endcase
        return inc;
    endfunction

    state_t       state_r;
    logic [4:0]   cnt_r;
    logic [49:0]  rad_r;
    logic [27:0]  rem_r;
    logic [24:0]  root_r;
    logic [7:0]   exp_r;
    logic [2:0]   rnd_r;
    logic         special_r;
    logic [31:0]  spec_res_r;
    logic [4:0]   spec_flags_r;

    logic [7:0]   a_exp_s;
    logic [22:0]  a_man_s;
    logic         special_s;
    logic [31:0]  spec_res_s;
    logic [4:0]   spec_flags_s;
    logic [4:0]   lz_s;
    logic [23:0]  sig_s;
    logic [24:0]  sig_adj_s;
    logic [9:0]   e_s;
    logic [9:0]   e_even_s;
    logic [9:0]   res_exp_w_s;
    logic [27:0]  rem_t_s;
    logic [27:0]  trial_s;
    logic [27:0]  rem_n_s;
    logic         ge_s;
    logic         g_s;
    logic         s_s;
    logic         inc_s;
    logic [24:0]  mant_s;
    logic [7:0]   exp_fin_s;
    logic [22:0]  frac_s;
    logic         finish_s;
    logic         unused_s;

    // Operand classification and normalisation into an even-exponent radicand.
    always_comb begin
        a_exp_s      = a_i[30:23];
        a_man_s      = a_i[22:0];
        special_s    = 1'b1;
        spec_res_s   = 32'h7FC0_0000;
        spec_flags_s = 5'b00000;
        if ((a_exp_s == 8'hFF) && (a_man_s != 23'd0)) begin
            spec_flags_s = {~a_man_s[22], 4'b0000};
        end else if (a_i[30:0] == 31'd0) begin
            spec_res_s = a_i;
        end else if (a_i[31]) begin
            spec_flags_s = 5'b10000;
        end else if (a_exp_s == 8'hFF) begin
            spec_res_s = 32'h7F80_0000;
        end else begin
            special_s = 1'b0;
        end
        lz_s = lzc24({1'b0, a_man_s});
        if (a_exp_s == 8'd0) begin
            sig_s = {1'b0, a_man_s} << lz_s;
            e_s   = 10'd0 - 10'd126 - {5'd0, lz_s};
        end else begin
            sig_s = {1'b1, a_man_s};
            e_s   = {2'b00, a_exp_s} - 10'd127;
        end
        if (e_s[0]) begin
            sig_adj_s = {sig_s, 1'b0};
            e_even_s  = e_s - 10'd1;
        end else begin
            sig_adj_s = {1'b0, sig_s};
            e_even_s  = e_s;
        end
        res_exp_w_s = 10'($signed(e_even_s) >>> 1) + 10'd127;
    end

    // One restoring digit-recurrence step and the final rounding stage.
    always_comb begin
        rem_t_s   = (rem_r << 2) | {26'd0, rad_r[49:48]};
        trial_s   = {1'b0, root_r, 2'b01};
        ge_s      = (rem_t_s >= trial_s);
        rem_n_s   = ge_s ? (rem_t_s - trial_s) : rem_t_s;
        g_s       = root_r[0];
        s_s       = (rem_r != 28'd0);
        inc_s     = round_inc(rnd_r, g_s, s_s, root_r[1]);
        mant_s    = {1'b0, root_r[24:1]} + {24'd0, inc_s};
        frac_s    = mant_s[24] ? mant_s[23:1] : mant_s[22:0];
        exp_fin_s = exp_r + {7'd0, mant_s[24]};
    end

`ifdef FP_SQRT_EARLY_OUT_EN
    assign finish_s = (cnt_r == 5'd25) || special_r;
`else
    assign finish_s = (cnt_r == 5'd25);
`endif

    assign unused_s = ^{res_exp_w_s[9:8], e_even_s[0]};

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 5'd0;
            rad_r        <= 50'd0;
            rem_r        <= 28'd0;
            root_r       <= 25'd0;
            exp_r        <= 8'd0;
            rnd_r        <= 3'd0;
            special_r    <= 1'b0;
            spec_res_r   <= 32'd0;
            spec_flags_r <= 5'd0;
            done_o       <= 1'b0;
            result_o     <= 32'd0;
            flags_o      <= 5'd0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        state_r      <= ST_BUSY;
                        cnt_r        <= 5'd0;
                        rad_r        <= {sig_adj_s, 25'd0};
                        rem_r        <= 28'd0;
                        root_r       <= 25'd0;
                        exp_r        <= res_exp_w_s[7:0];
                        rnd_r        <= rnd_i;
                        special_r    <= special_s;
                        spec_res_r   <= spec_res_s;
                        spec_flags_r <= spec_flags_s;
                    end
                end
                ST_BUSY: begin
                    if (finish_s) begin
                        state_r <= ST_IDLE;
                        done_o  <= 1'b1;
                        if (special_r) begin
                            result_o <= spec_res_r;
                            flags_o  <= spec_flags_r;
                        end else begin
                            result_o <= {1'b0, exp_fin_s, frac_s};
                            flags_o  <= {4'b0000, g_s | s_s};
                        end
                    end else begin
                        cnt_r  <= cnt_r + 5'd1;
                        rad_r  <= {rad_r[47:0], 2'b00};
                        rem_r  <= rem_n_s;
                        root_r <= {root_r[23:0], ge_s};
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_unit.sv
// Directed and random checks of fp_sqrt_unit against an integer-sqrt reference model.
module tb_fp_sqrt_unit;

    logic        clk;
    logic        reset_i;
    logic [31:0] a_i;
    logic        start_i;
    logic [2:0]  rnd_i;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  flags_o;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        logic        sp;
    } exp_t;
    exp_t sb_q[$];

    fp_sqrt_unit dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .a_i      (a_i),
        .start_i  (start_i),
        .rnd_i    (rnd_i),
        .done_o   (done_o),
        .result_o (result_o),
        .flags_o  (flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic void ref_sqrt(input logic [31:0] a, input logic [2:0] rm,
                                     output logic [31:0] res, output logic [4:0] fl,
                                     output logic sp);
        int          e;
        int          ex;
        longint      m, r, q, lo, hi, mid, rem, mant;
        logic        g, s, l, inc;
        logic [31:0] ex_v;
        sp = 1'b1;
        fl = 5'b00000;
        res = 32'h7FC0_0000;
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0) begin
            if (!a[22]) fl = 5'b10000;
        end else if (a[30:0] == 31'd0) begin
            res = a;
        end else if (a[31]) begin
            fl = 5'b10000;
        end else if (a[30:23] == 8'hFF) begin
            res = 32'h7F80_0000;
        end else begin
            sp = 1'b0;
            if (a[30:23] == 8'd0) begin
                m = longint'(a[22:0]);
                e = -126;
                while ((m & 64'h80_0000) == 0) begin
                    m = m << 1;
                    e = e - 1;
                end
            end else begin
                m = longint'({1'b1, a[22:0]});
                e = int'(a[30:23]) - 127;
            end
            if ((e & 1) != 0) begin
                m = m << 1;
                e = e - 1;
            end
            r  = m << 25;
            lo = 0;
            hi = 64'd1 << 25;
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if (mid * mid <= r) lo = mid;
                else hi = mid - 1;
            end
            q    = lo;
            rem  = r - q * q;
            g    = q[0];
            l    = q[1];
            s    = (rem != 0);
            if (rm == 3'd1 || rm == 3'd2) inc = 1'b0;
            else if (rm == 3'd3) inc = g || s;
            else if (rm == 3'd4) inc = g;
            else inc = g && (s || l);
            mant = (q >> 1) + longint'(inc);
            ex   = e / 2 + 127;
            if (mant == (64'd1 << 24)) begin
                mant = 64'd1 << 23;
                ex   = ex + 1;
            end
            ex_v = ex;
            res  = {1'b0, ex_v[7:0], mant[22:0]};
            fl   = {4'b0000, g | s};
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [2:0] rm);
        exp_t e;
        int   n;
        int   lat;
        ref_sqrt(a, rm, e.res, e.fl, e.sp);
        sb_q.push_back(e);
        @(negedge clk);
        a_i     = a;
        rnd_i   = rm;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = ~a;
        rnd_i   = rm + 3'd1;
        n = 0;
        while (n < 40 && !done_o) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb_q.pop_front();
`ifdef FP_SQRT_EARLY_OUT_EN
        lat = e.sp ? 1 : 26;
`else
        lat = 26;
`endif
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, result_o, e.res);
        chk({tag, " flags"}, {27'd0, flags_o}, {27'd0, e.fl});
    endtask

    initial begin
        int pulses;
        int first;
        logic [31:0] cap;
        vectors     = 0;
        miscompares = 0;
        reset_i = 1'b0;
        start_i = 1'b0;
        a_i     = 32'd0;
        rnd_i   = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset flags", {27'd0, flags_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b1;

        run_op("sqrt4 rne", 32'h4080_0000, 3'd0);
        chk("sqrt4 value", result_o, 32'h4000_0000);
        @(posedge clk);
        #1;
        chk("done single cycle", {31'd0, done_o}, 32'd0);
        chk("result hold", result_o, 32'h4000_0000);

        run_op("sqrt2 rtz", 32'h4000_0000, 3'd1);
        chk("sqrt2 rtz value", result_o, 32'h3FB5_04F3);
        run_op("sqrt2 rup", 32'h4000_0000, 3'd3);
        chk("sqrt2 rup value", result_o, 32'h3FB5_04F4);
        run_op("sqrt2 rne", 32'h4000_0000, 3'd0);
        chk("sqrt2 rne flags", {27'd0, flags_o}, 32'd1);
        run_op("sqrt2 rdn", 32'h4000_0000, 3'd2);
        run_op("sqrt2 rmm", 32'h4000_0000, 3'd4);
        run_op("sqrt2 code7", 32'h4000_0000, 3'd7);
        run_op("min subnormal", 32'h0000_0001, 3'd0);
        chk("min subnormal value", result_o, 32'h1A35_04F3);
        run_op("max subnormal", 32'h007F_FFFF, 3'd3);
        run_op("max normal", 32'h7F7F_FFFF, 3'd3);
        run_op("neg one", 32'hBF80_0000, 3'd0);
        chk("neg one flags", {27'd0, flags_o}, 32'h10);
        run_op("snan", 32'h7F80_0001, 3'd0);
        run_op("qnan", 32'h7FC0_0000, 3'd0);
        run_op("neg zero", 32'h8000_0000, 3'd0);
        chk("neg zero value", result_o, 32'h8000_0000);
        run_op("pos zero", 32'h0000_0000, 3'd0);
        run_op("pos inf", 32'h7F80_0000, 3'd0);
        run_op("neg inf", 32'hFF80_0000, 3'd0);

        // Start re-pulsed while busy must be ignored.
        @(negedge clk);
        a_i     = 32'h4080_0000;
        rnd_i   = 3'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = 32'hBF80_0000;
        pulses  = 0;
        first   = 0;
        cap     = 32'd0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) start_i = 1'b1;
            if (n == 7) start_i = 1'b0;
            if (done_o) begin
                pulses++;
                if (pulses == 1) begin
                    first = n;
                    cap   = result_o;
                end
            end
        end
        chk("busy restart pulses", 32'(pulses), 32'd1);
        chk("busy restart latency", 32'(first), 32'd26);
        chk("busy restart result", cap, 32'h4000_0000);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        a_i     = 32'h4000_0000;
        rnd_i   = 3'd3;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_i = 1'b0;
        #1;
        chk("abort done", {31'd0, done_o}, 32'd0);
        chk("abort result", result_o, 32'd0);
        chk("abort flags", {27'd0, flags_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b1;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        chk("abort no done", 32'(pulses), 32'd0);
        run_op("after abort", 32'h4000_0000, 3'd3);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [2:0]  rm;
            ra     = $urandom;
            ra[31] = 1'b0;
            if (i % 4 == 0) ra[30:23] = 8'd0;
            if (ra[30:23] == 8'hFF) ra[30:23] = 8'hFE;
            if (ra[30:0] == 31'd0) ra[0] = 1'b1;
            rm = 3'($urandom_range(0, 7));
            run_op("random", ra, rm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
